// File: rtl/multicycle_control_sequencer_if.sv
// multicycle_control_sequencer_if: IR fields, memory handshake and datapath strobes of the control sequencer
interface multicycle_control_sequencer_if;
   logic       run, zero, mem_ready;
   logic [5:0] opcode;
   logic [2:0] funct;
   logic       imem_req, dmem_read, dmem_write, ir_load, pc_write;
   logic [1:0] pc_src, alu_src_b;
   logic [2:0] alu_control, state;
   logic       reg_write, mem_to_reg, halted, illegal_op, bus_error;
   modport master(
      input  run, opcode, funct, zero, mem_ready,
      output imem_req, dmem_read, dmem_write, ir_load, pc_write, pc_src, alu_src_b,
             alu_control, reg_write, mem_to_reg, state, halted, illegal_op, bus_error
   );
   modport slave(
      output run, opcode, funct, zero, mem_ready,
      input  imem_req, dmem_read, dmem_write, ir_load, pc_write, pc_src, alu_src_b,
             alu_control, reg_write, mem_to_reg, state, halted, illegal_op, bus_error
   );
endinterface

// File: rtl/multicycle_control_sequencer.sv
// multicycle_control_sequencer: fetch/decode/exec/mem/wb control FSM with memory timeout.
// Optional PERF_COUNTERS_EN adds cycle_count/retired_count outputs.
module multicycle_control_sequencer #(
   parameter int MEM_TIMEOUT = 16
`ifdef PERF_COUNTERS_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input logic clk,
   input logic reset,
`ifdef PERF_COUNTERS_EN
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retired_count,
`endif
   multicycle_control_sequencer_if.master bus
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
   localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B,
                          OP_BEQ = 6'h04, OP_J = 6'h02, OP_HALT = 6'h3F;
   localparam logic [7:0] LIM = 8'(MEM_TIMEOUT - 1);
   state_t     st, nxt;
   logic [7:0] wcnt;
   logic       bus_err, waiting, timeout, is_lw;
   logic       imem_req, dmem_read, dmem_write, ir_load, pc_write, reg_write, mem_to_reg, illegal_op;
   logic [1:0] pc_src, alu_src_b;
   logic [2:0] alu_control;
   assign is_lw   = bus.opcode == OP_LW;
   assign waiting = (st == FETCH && bus.run) || st == MEM;
   // the cycle that would be the MEM_TIMEOUT-th unanswered wait cycle aborts, unless mem_ready arrives in it
   assign timeout = waiting && !bus.mem_ready && wcnt == LIM;
   always_comb begin
      nxt = st;
      imem_req = 1'b0;
      dmem_read = 1'b0;
      dmem_write = 1'b0;
      ir_load = 1'b0;
      pc_write = 1'b0;
      reg_write = 1'b0;
      mem_to_reg = 1'b0;
      illegal_op = 1'b0;
      pc_src = 2'd0;
      alu_src_b = 2'd0;
      alu_control = 3'd0;
      case (st)
         FETCH: if (bus.run) begin
            imem_req = 1'b1;
            alu_src_b = 2'd1;
            ir_load = bus.mem_ready;
            pc_write = bus.mem_ready;
            nxt = bus.mem_ready ? DECODE : timeout ? HALT : FETCH;
         end
         DECODE: nxt = EXEC;
         EXEC: case (bus.opcode)
            OP_R: begin
               alu_control = bus.funct;
               nxt = WB;
            end
            OP_ADDI: begin
               alu_src_b = 2'd2;
               nxt = WB;
            end
            OP_LW, OP_SW: begin
               alu_src_b = 2'd2;
               nxt = MEM;
            end
            OP_BEQ: begin
               alu_control = 3'd1;
               pc_write = bus.zero;
               pc_src = {1'b0, bus.zero};
               nxt = FETCH;
            end
            OP_J: begin
               pc_write = 1'b1;
               pc_src = 2'd2;
               nxt = FETCH;
            end
            OP_HALT: nxt = HALT;
            default: begin
               illegal_op = 1'b1;
               nxt = FETCH;
            end
         endcase
         MEM: begin
            dmem_read = is_lw;
            dmem_write = !is_lw;
            nxt = bus.mem_ready ? (is_lw ? WB : FETCH) : timeout ? HALT : MEM;
         end
         WB: begin
            reg_write = 1'b1;
            mem_to_reg = is_lw;
            nxt = FETCH;
         end
         HALT: nxt = HALT;
         default: nxt = FETCH;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         st <= FETCH;
         wcnt <= '0;
         bus_err <= 1'b0;
      end else begin
         st <= nxt;
         wcnt <= waiting && !bus.mem_ready ? wcnt + 8'd1 : '0;
         if (timeout) bus_err <= 1'b1;
      end
   // strobes are forced low while reset is held so an aborted cycle has no side effects
   assign bus.imem_req    = imem_req & ~reset;
   assign bus.dmem_read   = dmem_read & ~reset;
   assign bus.dmem_write  = dmem_write & ~reset;
   assign bus.ir_load     = ir_load & ~reset;
   assign bus.pc_write    = pc_write & ~reset;
   assign bus.reg_write   = reg_write & ~reset;
   assign bus.mem_to_reg  = mem_to_reg & ~reset;
   assign bus.illegal_op  = illegal_op & ~reset;
   assign bus.pc_src      = reset ? 2'd0 : pc_src;
   assign bus.alu_src_b   = reset ? 2'd0 : alu_src_b;
   assign bus.alu_control = reset ? 3'd0 : alu_control;
   assign bus.state       = st;
   assign bus.halted      = st == HALT;
   assign bus.bus_error   = bus_err;
`ifdef PERF_COUNTERS_EN
   always_ff @(posedge clk)
      if (reset) begin
         cycle_count <= '0;
         retired_count <= '0;
      end else begin
         if (st != HALT) cycle_count <= cycle_count + 1'b1;
         if (nxt == FETCH && (st == EXEC || st == MEM || st == WB)) retired_count <= retired_count + 1'b1;
      end
`endif
endmodule

// File: tb/tb_multicycle_control_sequencer.sv
// tb_multicycle_control_sequencer: directed per-cycle vectors checked through a scoreboard queue
module tb_multicycle_control_sequencer;
   typedef struct {
      logic [19:0] v;
      string       tag;
   } item_t;
   logic  clk = 1'b0, reset = 1'b1;
   item_t q[$];
   int    n_cmp = 0, n_bad = 0;
   multicycle_control_sequencer_if bus();
   multicycle_control_sequencer #(.MEM_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // {state, imem_req/dmem_read/dmem_write/ir_load/pc_write, pc_src, alu_src_b, alu_control,
   //  reg_write/mem_to_reg/halted/illegal_op/bus_error}
   function automatic logic [19:0] f(input logic [2:0] s, input logic [4:0] req, input logic [1:0] pcs,
                                     input logic [1:0] asb, input logic [2:0] alu, input logic [4:0] flg);
      return {s, req, pcs, asb, alu, flg};
   endfunction
   task automatic cyc(input logic rst, input logic rn, input logic [5:0] op, input logic [2:0] fn,
                      input logic z, input logic rdy, input logic [19:0] e, input string tag);
      item_t it;
      @(posedge clk);
      #1;
      reset = rst;
      bus.run = rn;
      bus.opcode = op;
      bus.funct = fn;
      bus.zero = z;
      bus.mem_ready = rdy;
      it.v = e;
      it.tag = tag;
      q.push_back(it);
   endtask
   always @(negedge clk)
      if (q.size() != 0) begin
         item_t it;
         logic [19:0] got;
         it = q.pop_front();
         got = {bus.state, bus.imem_req, bus.dmem_read, bus.dmem_write, bus.ir_load, bus.pc_write,
                bus.pc_src, bus.alu_src_b, bus.alu_control,
                bus.reg_write, bus.mem_to_reg, bus.halted, bus.illegal_op, bus.bus_error};
         n_cmp++;
         if (got !== it.v) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", it.tag, got, it.v);
         end
      end
   localparam logic [19:0] FET = f(3'd0, 5'b10011, 2'd0, 2'd1, 3'd0, 5'b0);
   localparam logic [19:0] DEC = f(3'd1, 5'b0, 2'd0, 2'd0, 3'd0, 5'b0);
   localparam logic [19:0] IDLE = f(3'd0, 5'b0, 2'd0, 2'd0, 3'd0, 5'b0);
   initial begin
      bus.run = 1'b1;
      bus.opcode = 6'h08;
      bus.funct = 3'd0;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b1;
      cyc(1, 1, 6'h08, 3'd0, 0, 1, IDLE, "reset");
      cyc(0, 1, 6'h08, 3'd0, 0, 1, FET, "addi_fetch");
      cyc(0, 1, 6'h08, 3'd0, 0, 1, DEC, "addi_decode");
      cyc(0, 1, 6'h08, 3'd0, 0, 1, f(3'd2, 5'b0, 2'd0, 2'd2, 3'd0, 5'b0), "addi_exec");
      cyc(0, 1, 6'h08, 3'd0, 0, 1, f(3'd4, 5'b0, 2'd0, 2'd0, 3'd0, 5'b10000), "addi_wb");
      cyc(0, 1, 6'h23, 3'd0, 0, 1, FET, "lw_fetch");
      cyc(0, 1, 6'h23, 3'd0, 0, 1, DEC, "lw_decode");
      cyc(0, 1, 6'h23, 3'd0, 0, 1, f(3'd2, 5'b0, 2'd0, 2'd2, 3'd0, 5'b0), "lw_exec");
      for (int i = 0; i < 4; i++)
         cyc(0, 1, 6'h23, 3'd0, 0, i == 3, f(3'd3, 5'b01000, 2'd0, 2'd0, 3'd0, 5'b0), $sformatf("lw_mem%0d", i));
      cyc(0, 1, 6'h23, 3'd0, 0, 1, f(3'd4, 5'b0, 2'd0, 2'd0, 3'd0, 5'b11000), "lw_wb");
      cyc(0, 1, 6'h04, 3'd0, 1, 1, FET, "beq1_fetch");
      cyc(0, 1, 6'h04, 3'd0, 1, 1, DEC, "beq1_decode");
      cyc(0, 1, 6'h04, 3'd0, 1, 1, f(3'd2, 5'b00001, 2'd1, 2'd0, 3'd1, 5'b0), "beq1_exec");
      cyc(0, 1, 6'h04, 3'd0, 0, 1, FET, "beq0_fetch");
      cyc(0, 1, 6'h04, 3'd0, 0, 1, DEC, "beq0_decode");
      cyc(0, 1, 6'h04, 3'd0, 0, 1, f(3'd2, 5'b0, 2'd0, 2'd0, 3'd1, 5'b0), "beq0_exec");
      cyc(0, 1, 6'h15, 3'd0, 0, 1, FET, "ill_fetch");
      cyc(0, 1, 6'h15, 3'd0, 0, 1, DEC, "ill_decode");
      cyc(0, 1, 6'h15, 3'd0, 0, 1, f(3'd2, 5'b0, 2'd0, 2'd0, 3'd0, 5'b00010), "ill_exec");
      cyc(0, 1, 6'h00, 3'd6, 0, 1, FET, "r_fetch");
      cyc(0, 1, 6'h00, 3'd6, 0, 1, DEC, "r_decode");
      cyc(0, 1, 6'h00, 3'd6, 0, 1, f(3'd2, 5'b0, 2'd0, 2'd0, 3'd6, 5'b0), "r_exec");
      cyc(0, 1, 6'h00, 3'd6, 0, 1, f(3'd4, 5'b0, 2'd0, 2'd0, 3'd0, 5'b10000), "r_wb");
      cyc(0, 1, 6'h02, 3'd0, 0, 1, FET, "j_fetch");
      cyc(0, 1, 6'h02, 3'd0, 0, 1, DEC, "j_decode");
      cyc(0, 1, 6'h02, 3'd0, 0, 1, f(3'd2, 5'b00001, 2'd2, 2'd0, 3'd0, 5'b0), "j_exec");
      cyc(0, 1, 6'h2B, 3'd0, 0, 1, FET, "sw_fetch");
      cyc(0, 1, 6'h2B, 3'd0, 0, 1, DEC, "sw_decode");
      cyc(0, 1, 6'h2B, 3'd0, 0, 1, f(3'd2, 5'b0, 2'd0, 2'd2, 3'd0, 5'b0), "sw_exec");
      cyc(0, 1, 6'h2B, 3'd0, 0, 0, f(3'd3, 5'b00100, 2'd0, 2'd0, 3'd0, 5'b0), "sw_mem0");
      cyc(0, 1, 6'h2B, 3'd0, 0, 0, f(3'd3, 5'b00100, 2'd0, 2'd0, 3'd0, 5'b0), "sw_mem1");
      cyc(1, 1, 6'h2B, 3'd0, 0, 0, f(3'd3, 5'b0, 2'd0, 2'd0, 3'd0, 5'b0), "sw_reset");
      cyc(0, 0, 6'h2B, 3'd0, 0, 0, IDLE, "post_reset0");
      cyc(0, 0, 6'h2B, 3'd0, 0, 1, IDLE, "post_reset1");
      cyc(0, 1, 6'h2B, 3'd0, 0, 1, FET, "sw2_fetch");
      cyc(0, 1, 6'h2B, 3'd0, 0, 1, DEC, "sw2_decode");
      cyc(0, 1, 6'h2B, 3'd0, 0, 1, f(3'd2, 5'b0, 2'd0, 2'd2, 3'd0, 5'b0), "sw2_exec");
      cyc(0, 1, 6'h2B, 3'd0, 0, 1, f(3'd3, 5'b00100, 2'd0, 2'd0, 3'd0, 5'b0), "sw2_mem");
      cyc(0, 0, 6'h2B, 3'd0, 0, 1, IDLE, "sw2_done");
      for (int i = 0; i < 4; i++)
         cyc(0, 1, 6'h08, 3'd0, 0, 0, f(3'd0, 5'b10000, 2'd0, 2'd1, 3'd0, 5'b0), $sformatf("tmo_wait%0d", i));
      cyc(0, 1, 6'h08, 3'd0, 0, 0, f(3'd5, 5'b0, 2'd0, 2'd0, 3'd0, 5'b00101), "tmo_halt0");
      cyc(0, 1, 6'h08, 3'd0, 0, 1, f(3'd5, 5'b0, 2'd0, 2'd0, 3'd0, 5'b00101), "tmo_halt1");
      cyc(1, 1, 6'h08, 3'd0, 0, 1, f(3'd5, 5'b0, 2'd0, 2'd0, 3'd0, 5'b00101), "tmo_reset");
      cyc(0, 0, 6'h08, 3'd0, 0, 1, IDLE, "tmo_cleared");
      cyc(0, 1, 6'h3F, 3'd0, 0, 1, FET, "halt_fetch");
      cyc(0, 1, 6'h3F, 3'd0, 0, 1, DEC, "halt_decode");
      cyc(0, 1, 6'h3F, 3'd0, 0, 1, f(3'd2, 5'b0, 2'd0, 2'd0, 3'd0, 5'b0), "halt_exec");
      cyc(0, 1, 6'h3F, 3'd0, 0, 1, f(3'd5, 5'b0, 2'd0, 2'd0, 3'd0, 5'b00100), "halt_state");
      cyc(0, 0, 6'h3F, 3'd0, 0, 0, f(3'd5, 5'b0, 2'd0, 2'd0, 3'd0, 5'b00100), "halt_stays");
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d vectors left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
